mult_div_unit: RTL and testbench

Execute-stage multiply/divide unit owning the architectural HI and LO registers. It sits directly downstream of the EX-stage instruction decode. It consumes the `start`, `MULTDIVop`, `MULTDIVwe`, `HiLo` and `HILOsel` controls together with the forwarded rs/rt operands. It runs multi-cycle mult/multu/div/divu, services mthi/mtlo writes, returns the selected HI/LO value for mfhi/mflo, and reports `busy` to the hazard unit for stalling.

---
 rtl/mdu_pkg.sv | 12 +
 rtl/mult_div_core.sv | 48 ++++
 rtl/mult_div_unit.sv | 70 +++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - opcode encodings and default latencies for the multiply/divide unit
package mdu_pkg;

   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_core.sv
// rtl/mult_div_core.sv - combinational 32x32 multiply / divide datapath producing {hi,lo}
module mult_div_core
   import mdu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  op,
   output logic [63:0] result,
   output logic        div_zero
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor;
   logic [31:0] quot_u;
   logic [31:0] rem_u;
   logic        neg_a;
   logic        neg_b;

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide goes through magnitudes so the most-negative/-1 case stays well defined.
   assign neg_a   = (op == MD_DIV) && a[31];
   assign neg_b   = (op == MD_DIV) && b[31];
   assign mag_a   = neg_a ? (~a + 32'd1) : a;
   assign mag_b   = neg_b ? (~b + 32'd1) : b;
   assign divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
   assign quot_u  = mag_a / divisor;
   assign rem_u   = mag_a % divisor;

   assign div_zero = (b == 32'd0);

   always_comb begin
      result = 64'd0;
      case (op)
         MD_MULTU: result = prod_u;
         MD_MULT:  result = prod_s;
         default: begin
            result[31:0]  = (neg_a ^ neg_b) ? (~quot_u + 32'd1) : quot_u;
            result[63:32] = neg_a ? (~rem_u + 32'd1) : rem_u;
         end
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - EX-stage multi-cycle mult/div unit owning the HI/LO registers
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        start,
   input  logic [1:0]  MULTDIVop,
   input  logic        MULTDIVwe,
   input  logic        HiLo,
   input  logic        HILOsel,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] HILOout
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] cnt;
   logic [31:0]   hi_p;
   logic [31:0]   lo_p;
   logic          nochg;
   logic [63:0]   core_result;
   logic          core_div_zero;

   mult_div_core u_core (
      .a        (A),
      .b        (B),
      .op       (MULTDIVop),
      .result   (core_result),
      .div_zero (core_div_zero)
   );

   assign busy    = (cnt != '0);
   assign HILOout = HILOsel ? LO : HI;

   // Result is captured at launch so operand changes during the busy window are harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         HI    <= 32'd0;
         LO    <= 32'd0;
         hi_p  <= 32'd0;
         lo_p  <= 32'd0;
         cnt   <= '0;
         nochg <= 1'b0;
      end else if (busy) begin
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1) && !nochg) begin
            HI <= hi_p;
            LO <= lo_p;
         end
      end else if (start) begin
         hi_p  <= core_result[63:32];
         lo_p  <= core_result[31:0];
         nochg <= MULTDIVop[1] && core_div_zero;
         cnt   <= MULTDIVop[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (MULTDIVwe) begin
         if (HiLo) HI <= A;
         else      LO <= A;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic        start;
   logic [1:0]  MULTDIVop;
   logic        MULTDIVwe;
   logic        HiLo;
   logic        HILOsel;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] HILOout;

   int checks   = 0;
   int failures = 0;
   int cycles;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .start     (start),
      .MULTDIVop (MULTDIVop),
      .MULTDIVwe (MULTDIVwe),
      .HiLo      (HiLo),
      .HILOsel   (HILOsel),
      .busy      (busy),
      .HI        (HI),
      .LO        (LO),
      .HILOout   (HILOout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse start for one edge, then count negedges with busy high (bounded).
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
      A = a; B = b; MULTDIVop = op; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic write_reg(input logic hi, input logic [31:0] val);
      A = val; HiLo = hi; MULTDIVwe = 1'b1;
      @(negedge clk);
      MULTDIVwe = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; A = '0; B = '0; start = 1'b0; MULTDIVop = 2'b00;
      MULTDIVwe = 1'b0; HiLo = 1'b0; HILOsel = 1'b0;
      #12;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", HI, 32'd0);
      check("reset_lo", LO, 32'd0);
      check("reset_hiloout", HILOout, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // mult -2 * 3; HI must not move during the busy window
      A = 32'hFFFFFFFE; B = 32'd3; MULTDIVop = 2'b01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("mult_busy_first", {31'd0, busy}, 32'd1);
      check("mult_hi_pending", HI, 32'd0);
      cycles = 1;
      @(negedge clk);
      while (busy && cycles < 50) begin
         cycles++;
         @(negedge clk);
      end
      check("mult_cycles", cycles, 32'd5);
      check("mult_hi", HI, 32'hFFFFFFFF);
      check("mult_lo", LO, 32'hFFFFFFFA);

      run_op(2'b00, 32'hFFFFFFFE, 32'd3, cycles);
      check("multu_cycles", cycles, 32'd5);
      check("multu_hi", HI, 32'h00000002);
      check("multu_lo", LO, 32'hFFFFFFFA);

      run_op(2'b11, 32'hFFFFFFF9, 32'd2, cycles);
      check("div_cycles", cycles, 32'd10);
      check("div_lo", LO, 32'hFFFFFFFD);
      check("div_hi", HI, 32'hFFFFFFFF);

      run_op(2'b11, 32'd7, 32'hFFFFFFFE, cycles);
      check("div_negb_lo", LO, 32'hFFFFFFFD);
      check("div_negb_hi", HI, 32'd1);

      run_op(2'b10, 32'd100, 32'd7, cycles);
      check("divu_lo", LO, 32'd14);
      check("divu_hi", HI, 32'd2);

      // divide by zero keeps preloaded values
      write_reg(1'b1, 32'h1111);
      write_reg(1'b0, 32'h2222);
      check("mthi", HI, 32'h1111);
      check("mtlo", LO, 32'h2222);
      run_op(2'b10, 32'd55, 32'd0, cycles);
      check("divz_cycles", cycles, 32'd10);
      check("divz_hi", HI, 32'h1111);
      check("divz_lo", LO, 32'h2222);

      // mtlo with read mux
      HILOsel = 1'b1;
      write_reg(1'b0, 32'h1234);
      check("mtlo_lo", LO, 32'h1234);
      check("mtlo_hiloout", HILOout, 32'h1234);
      HILOsel = 1'b0;
      #1;
      check("hiloout_hi", HILOout, 32'h1111);

      // write while busy is ignored
      A = 32'd5; B = 32'd6; MULTDIVop = 2'b01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = 32'hDEAD; HiLo = 1'b1; MULTDIVwe = 1'b1;
      @(negedge clk);
      check("busy_write_hi", HI, 32'h1111);
      MULTDIVwe = 1'b0;
      cycles = 0;
      while (busy && cycles < 50) begin
         cycles++;
         @(negedge clk);
      end
      check("busy_write_done_hi", HI, 32'd0);
      check("busy_write_done_lo", LO, 32'd30);

      // back-to-back start in the first idle cycle, combined with a write that must be dropped
      A = 32'd2; B = 32'd3; MULTDIVop = 2'b00; start = 1'b1; MULTDIVwe = 1'b1; HiLo = 1'b1;
      @(negedge clk);
      start = 1'b0; MULTDIVwe = 1'b0;
      check("prio_busy", {31'd0, busy}, 32'd1);
      check("prio_hi_nowrite", HI, 32'd0);
      cycles = 0;
      while (busy && cycles < 50) begin
         cycles++;
         @(negedge clk);
      end
      check("prio_hi", HI, 32'd0);
      check("prio_lo", LO, 32'd6);

      run_op(2'b00, 32'h10000, 32'h10000, cycles);
      check("b2b_hi", HI, 32'd1);
      check("b2b_lo", LO, 32'd0);

      // reset mid-operation
      A = 32'hFFFFFFFE; B = 32'd3; MULTDIVop = 2'b01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_hi", HI, 32'd0);
      check("rstmid_lo", LO, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("rstmid_late_hi", HI, 32'd0);
      check("rstmid_late_lo", LO, 32'd0);
      check("rstmid_late_busy", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
